cordic_rot_arbiter: RTL and testbench
=====================================

// Module: cordic_rot_arbiter
// PURPOSE
//  Time-shares one iterative rotation-CORDIC engine between NREQ requesters in the QR/matrix-inverse
//  datapath (row-pair lanes, Q-matrix sin/cos lane). Round-robin arbitration, operand capture,
//  engine start sequencing, done detection, result return, engine-hang watchdog.
//  Sits between the inversion top-level FSM and a single rot_cordic instance.
// PARAMETERS
//  SIZE  16  operand/result width, signed Q4.12 (angle in radians, Q4.12)
//  NREQ  3   number of requesters (2..8)
//  TMO   64  max WAIT cycles before watchdog abort (>= engine latency + 2)
// PORTS
//  clk          in   1          clock, rising edge
//  rst_n        in   1          asynchronous, active-low reset
//  req_i        in   NREQ       per-requester request level
//  x_i          in   NREQ*SIZE  X operand, requester k at [k*SIZE +: SIZE]
//  y_i          in   NREQ*SIZE  Y operand, same packing
//  angle_i      in   NREQ*SIZE  rotation angle, same packing
//  ack_o        out  NREQ       one-hot 1-cycle pulse: operands captured
//  res_valid_o  out  NREQ       one-hot 1-cycle pulse: x_o/y_o valid for that requester
//  x_o, y_o     out  SIZE       result bus shared by all requesters (holds until next result)
//  busy_o       out  1          high in any state other than IDLE
//  err_o        out  1          sticky watchdog flag, cleared only by reset
//  eng_start_o  out  1          1-cycle engine start pulse
//  eng_x_o, eng_y_o, eng_angle_o  out  SIZE  registered engine operands, stable ISSUE..WAIT
//  eng_x_i, eng_y_i  in  SIZE   engine results
//  eng_done_i   in   1          engine done (pulse or level)
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0, operand/result regs 0, rr_last=NREQ-1, done_q=0, wd_cnt=0.
//  Reset mid-operation: in-flight op dropped, no res_valid issued; engine must drop done on next start.
//  FSM: IDLE -> ISSUE -> WAIT -> IDLE.
//   IDLE: if |req_i: grant g = first set bit searching from (rr_last+1) mod NREQ upward, wrapping;
//         capture x/y/angle[g] into eng_*_o, ack_o[g]<=1, gnt<=g, rr_last<=g, -> ISSUE. Else stay.
//   ISSUE: eng_start_o=1 (decoded from state), ack_o cleared, wd_cnt<=0, -> WAIT.
//   WAIT: done_rise = eng_done_i & ~done_q (done_q = eng_done_i registered every cycle, all states).
//         done_rise: x_o<=eng_x_i, y_o<=eng_y_i, res_valid_o[gnt]<=1, -> IDLE.
//         else wd_cnt++; wd_cnt==TMO-1: err_o<=1, x_o<=0, y_o<=0, res_valid_o[gnt]<=1, -> IDLE.
//  res_valid_o/ack_o self-clear after 1 cycle. Only rising edge of done counts, so a level-held done
//   from a previous op never completes a new one.
//  Latency: req sampled at edge 0 -> ack_o & eng_start_o high cycle 1 -> WAIT from cycle 2;
//   done_rise in cycle k -> res_valid_o high cycle k+1, IDLE in cycle k+1, next grant ack at k+2.
//  Requester contract: hold req_i and operands stable until ack_o; drop req_i the cycle after ack
//   unless issuing another op. req_i sampled only in IDLE; withdrawal before grant is legal, no effect.
//  Simultaneous req: strictly round-robin; a requester re-requesting after its own grant ranks last.
//  Requests during ISSUE/WAIT wait (no queueing beyond the request level). No arithmetic on data;
//   operands pass unmodified (sign handling e.g. angle negation is the requester's job).
// TESTING (bench: behavioural engine, done pulses 12 cycles after start, Q4.12 exact cos/sin)
//  1 Single req0: x=0x1000,y=0,ang=0x0861 (30deg) -> ack_o=001 cycle1, start cycle1,
//    res_valid_o=001 cycle 14, x_o~0x0DDB, y_o~0x0800 (+-2 LSB).
//  2 req_i=111 held, 3 ops -> grant order 0,1,2, then 0 again on 4th; one-hot ack/res_valid each op.
//  3 Engine holds done high between ops -> second op completes only on fresh rising edge, no early
//    res_valid_o.
//  4 Engine never asserts done, TMO=64 -> err_o=1 and res_valid_o[g]=1, x_o=y_o=0 in WAIT cycle 64;
//    next req still serviced; err_o stays 1.
//  5 rst_n low during WAIT -> all outputs 0 asynchronously; after release, req1 is granted first
//    only if req0 absent (rr_last=NREQ-1).
//  6 req2 pulses 1 cycle during WAIT then drops -> never acked; busy_o low after current result.

Source files
------------

// File: rtl/cordic_rot_arbiter.sv
// Round-robin arbiter that time-shares one iterative rotation-CORDIC engine between NREQ
// requesters: operand capture, start sequencing, done-edge detection, result return, watchdog.
module cordic_rot_arbiter #(
   parameter int SIZE = 16,
   parameter int NREQ = 3,
   parameter int TMO  = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_i,
   input  logic [NREQ*SIZE-1:0] x_i,
   input  logic [NREQ*SIZE-1:0] y_i,
   input  logic [NREQ*SIZE-1:0] angle_i,
   output logic [NREQ-1:0]      ack_o,
   output logic [NREQ-1:0]      res_valid_o,
   output logic [SIZE-1:0]      x_o,
   output logic [SIZE-1:0]      y_o,
   output logic                 busy_o,
   output logic                 err_o,
   output logic                 eng_start_o,
   output logic [SIZE-1:0]      eng_x_o,
   output logic [SIZE-1:0]      eng_y_o,
   output logic [SIZE-1:0]      eng_angle_o,
   input  logic [SIZE-1:0]      eng_x_i,
   input  logic [SIZE-1:0]      eng_y_i,
   input  logic                 eng_done_i
);

   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int WD_W  = (TMO > 1) ? $clog2(TMO) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);
   localparam logic [IDX_W:0]   NREQ_W   = (IDX_W + 1)'(NREQ);
   localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TMO - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT
   } state_t;

   state_t            state;
   logic [IDX_W-1:0]  gnt;
   logic [IDX_W-1:0]  rr_last;
   logic              done_q;
   logic [WD_W-1:0]   wd_cnt;

   logic [IDX_W-1:0]  gnt_nxt;
   logic [IDX_W:0]    cand;
   logic              found;
   logic [SIZE-1:0]   sel_x, sel_y, sel_angle;
   logic              done_rise;

   // Rotating-priority search starting just past the last winner, so a requester that was
   // just served ranks last among simultaneous requests.
   always_comb begin
      // NOTE: every variable gets a default before any conditional write so no latch is inferred.
      gnt_nxt   = rr_last;
      cand      = '0;
      found     = 1'b0;
      sel_x     = '0;
      sel_y     = '0;
      sel_angle = '0;
      for (int i = 1; i <= NREQ; i++) begin
         cand = {1'b0, rr_last} + (IDX_W + 1)'(i);
         if (cand >= NREQ_W) cand = cand - NREQ_W;
         if (!found && req_i[cand[IDX_W-1:0]]) begin
            found   = 1'b1;
            gnt_nxt = cand[IDX_W-1:0];
         end
      end
      for (int k = 0; k < NREQ; k++) begin
         if (gnt_nxt == IDX_W'(k)) begin
            sel_x     = x_i[k*SIZE +: SIZE];
            sel_y     = y_i[k*SIZE +: SIZE];
            sel_angle = angle_i[k*SIZE +: SIZE];
         end
      end
   end

   // Only a fresh rising edge completes an op, so a done level left over from the previous
   // operation cannot retire the next one.
   assign done_rise   = eng_done_i & ~done_q;
   assign busy_o      = (state != S_IDLE);
   assign eng_start_o = (state == S_ISSUE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         ack_o       <= '0;
         res_valid_o <= '0;
         x_o         <= '0;
         y_o         <= '0;
         err_o       <= 1'b0;
         eng_x_o     <= '0;
         eng_y_o     <= '0;
         eng_angle_o <= '0;
         gnt         <= '0;
         rr_last     <= LAST_IDX;
         done_q      <= 1'b0;
         wd_cnt      <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every branch sees pre-edge state.
         done_q      <= eng_done_i;
         ack_o       <= '0;
         res_valid_o <= '0;
         unique case (state)
            S_IDLE: begin
               if (found) begin
                  eng_x_o        <= sel_x;
                  eng_y_o        <= sel_y;
                  eng_angle_o    <= sel_angle;
                  ack_o[gnt_nxt] <= 1'b1;
                  gnt            <= gnt_nxt;
                  rr_last        <= gnt_nxt;
                  state          <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               wd_cnt <= '0;
               state  <= S_WAIT;
            end
            S_WAIT: begin
               if (done_rise) begin
                  x_o              <= eng_x_i;
                  y_o              <= eng_y_i;
                  res_valid_o[gnt] <= 1'b1;
                  state            <= S_IDLE;
               end else if (wd_cnt == WD_MAX) begin
                  // Hung engine: return a zero result so the requester is never left waiting.
                  err_o            <= 1'b1;
                  x_o              <= '0;
                  y_o              <= '0;
                  res_valid_o[gnt] <= 1'b1;
                  state            <= S_IDLE;
               end else begin
                  wd_cnt <= wd_cnt + WD_W'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_rot_arbiter.sv
// Directed bench for cordic_rot_arbiter with a behavioural rotation engine whose done
// rises 12 cycles after start (pulse, held-level, or never).
module tb_cordic_rot_arbiter;

   localparam int SIZE = 16;
   localparam int NREQ = 3;
   localparam int TMO  = 64;

   typedef enum int {ENG_PULSE, ENG_HOLD, ENG_NEVER} eng_mode_t;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [NREQ-1:0]      req_i = '0;
   logic [NREQ*SIZE-1:0] x_i = '0, y_i = '0, angle_i = '0;
   logic [NREQ-1:0]      ack_o, res_valid_o;
   logic [SIZE-1:0]      x_o, y_o;
   logic                 busy_o, err_o, eng_start_o;
   logic [SIZE-1:0]      eng_x_o, eng_y_o, eng_angle_o;
   logic [SIZE-1:0]      eng_x_i, eng_y_i;
   logic                 eng_done_i;

   int        checks = 0;
   int        errors = 0;
   eng_mode_t eng_mode = ENG_PULSE;
   logic [SIZE-1:0] xs [NREQ];
   logic [SIZE-1:0] ys [NREQ];
   logic [SIZE-1:0] as [NREQ];

   cordic_rot_arbiter #(.SIZE(SIZE), .NREQ(NREQ), .TMO(TMO)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_i       (req_i),
      .x_i         (x_i),
      .y_i         (y_i),
      .angle_i     (angle_i),
      .ack_o       (ack_o),
      .res_valid_o (res_valid_o),
      .x_o         (x_o),
      .y_o         (y_o),
      .busy_o      (busy_o),
      .err_o       (err_o),
      .eng_start_o (eng_start_o),
      .eng_x_o     (eng_x_o),
      .eng_y_o     (eng_y_o),
      .eng_angle_o (eng_angle_o),
      .eng_x_i     (eng_x_i),
      .eng_y_i     (eng_y_i),
      .eng_done_i  (eng_done_i)
   );

   always #5 clk = ~clk;

   function automatic logic [SIZE-1:0] rot_x(input logic [SIZE-1:0] x, y, a);
      real xr, yr, ar;
      int  r;
      xr = $itor($signed(x));
      yr = $itor($signed(y));
      ar = $itor($signed(a)) / 4096.0;
      r  = $rtoi($floor(xr * $cos(ar) - yr * $sin(ar) + 0.5));
      return r[SIZE-1:0];
   endfunction

   function automatic logic [SIZE-1:0] rot_y(input logic [SIZE-1:0] x, y, a);
      real xr, yr, ar;
      int  r;
      xr = $itor($signed(x));
      yr = $itor($signed(y));
      ar = $itor($signed(a)) / 4096.0;
      r  = $rtoi($floor(xr * $sin(ar) + yr * $cos(ar) + 0.5));
      return r[SIZE-1:0];
   endfunction

   // Behavioural engine: start seen at edge s, done rises at edge s+11 (12 cycles after start).
   logic [SIZE-1:0] ex, ey, ea;
   int              eng_cnt;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eng_done_i <= 1'b0;
         eng_cnt    <= 0;
         eng_x_i    <= '0;
         eng_y_i    <= '0;
         ex <= '0; ey <= '0; ea <= '0;
      end else if (eng_start_o) begin
         eng_cnt <= 11;
         ex <= eng_x_o; ey <= eng_y_o; ea <= eng_angle_o;
         eng_x_i <= 16'hBAD1;
         eng_y_i <= 16'hBAD2;
         if (eng_mode != ENG_HOLD) eng_done_i <= 1'b0;
      end else begin
         if (eng_cnt > 0) eng_cnt <= eng_cnt - 1;
         if (eng_cnt == 1 && eng_mode != ENG_NEVER) begin
            eng_done_i <= 1'b1;
            eng_x_i    <= rot_x(ex, ey, ea);
            eng_y_i    <= rot_y(ex, ey, ea);
         end else if (eng_mode == ENG_PULSE || (eng_mode == ENG_HOLD && eng_cnt == 9)) begin
            eng_done_i <= 1'b0;
         end
      end
   end

   task automatic load_ops();
      for (int k = 0; k < NREQ; k++) begin
         x_i[k*SIZE +: SIZE]     = xs[k];
         y_i[k*SIZE +: SIZE]     = ys[k];
         angle_i[k*SIZE +: SIZE] = as[k];
      end
   endtask

   // Bounded waits: return number of falling edges until the event, or -1 on timeout.
   task automatic wait_ack(output int n);
      n = 0;
      do begin @(negedge clk); n++; end while (ack_o == '0 && n < 200);
      if (ack_o == '0) n = -1;
   endtask

   task automatic wait_res(output int n);
      n = 0;
      do begin @(negedge clk); n++; end while (res_valid_o == '0 && n < 200);
      if (res_valid_o == '0) n = -1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (ack_o !== '0 || res_valid_o !== '0 || busy_o !== 1'b0 || err_o !== 1'b0 || eng_start_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: ack=%b res=%b busy=%b err=%b start=%b, want all 0", ack_o, res_valid_o, busy_o, err_o, eng_start_o);
      end
      checks++;
      if (x_o !== '0 || y_o !== '0 || eng_x_o !== '0 || eng_y_o !== '0 || eng_angle_o !== '0) begin
         errors++;
         $display("FAIL reset_data: x=%h y=%h ex=%h ey=%h ea=%h, want all 0", x_o, y_o, eng_x_o, eng_y_o, eng_angle_o);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_round_robin();
      int n;
      int exp_g [4] = '{0, 1, 2, 0};
      logic [NREQ-1:0] g;
      xs = '{16'h0100, 16'h0300, 16'h0500};
      ys = '{16'h0200, 16'h0400, 16'h0600};
      as = '{16'h0010, 16'h0020, 16'h0030};
      load_ops();
      req_i = 3'b111;
      for (int op = 0; op < 4; op++) begin
         g = '0;
         g[exp_g[op]] = 1'b1;
         wait_ack(n);
         checks++;
         if (n != 1 || ack_o !== g || eng_start_o !== 1'b1) begin
            errors++;
            $display("FAIL rr_ack op%0d: n=%0d ack=%b start=%b, want n=1 ack=%b start=1", op, n, ack_o, eng_start_o, g);
         end
         checks++;
         if (eng_x_o !== xs[exp_g[op]] || eng_y_o !== ys[exp_g[op]] || eng_angle_o !== as[exp_g[op]]) begin
            errors++;
            $display("FAIL rr_operands op%0d: got %h/%h/%h, want %h/%h/%h", op, eng_x_o, eng_y_o, eng_angle_o,
                     xs[exp_g[op]], ys[exp_g[op]], as[exp_g[op]]);
         end
         if (op == 3) req_i = '0;
         wait_res(n);
         checks++;
         if (n != 13 || res_valid_o !== g) begin
            errors++;
            $display("FAIL rr_result op%0d: n=%0d res=%b, want n=13 res=%b", op, n, res_valid_o, g);
         end
         checks++;
         if (x_o !== rot_x(xs[exp_g[op]], ys[exp_g[op]], as[exp_g[op]]) ||
             y_o !== rot_y(xs[exp_g[op]], ys[exp_g[op]], as[exp_g[op]])) begin
            errors++;
            $display("FAIL rr_data op%0d: got x=%h y=%h, want x=%h y=%h", op, x_o, y_o,
                     rot_x(xs[exp_g[op]], ys[exp_g[op]], as[exp_g[op]]), rot_y(xs[exp_g[op]], ys[exp_g[op]], as[exp_g[op]]));
         end
      end
   endtask

   task automatic test_single();
      int n, dx, dy;
      xs[0] = 16'h1000; ys[0] = 16'h0000; as[0] = 16'h0861;
      load_ops();
      req_i = 3'b001;
      wait_ack(n);
      checks++;
      if (n != 1 || ack_o !== 3'b001 || eng_start_o !== 1'b1 || busy_o !== 1'b1) begin
         errors++;
         $display("FAIL single_ack: n=%0d ack=%b start=%b busy=%b, want n=1 ack=001 start=1 busy=1", n, ack_o, eng_start_o, busy_o);
      end
      req_i = '0;
      wait_res(n);
      checks++;
      if (n != 13 || res_valid_o !== 3'b001) begin
         errors++;
         $display("FAIL single_latency: n=%0d res=%b, want n=13 res=001", n, res_valid_o);
      end
      dx = int'($signed(x_o)) - 32'sh0DDB;
      dy = int'($signed(y_o)) - 32'sh0800;
      checks++;
      if (dx > 2 || dx < -2 || dy > 2 || dy < -2) begin
         errors++;
         $display("FAIL single_value: got x=%h y=%h, want x=0ddb y=0800 (+-2)", x_o, y_o);
      end
      @(negedge clk);
      checks++;
      if (res_valid_o !== '0 || busy_o !== 1'b0 || x_o !== rot_x(16'h1000, 16'h0000, 16'h0861)) begin
         errors++;
         $display("FAIL single_after: res=%b busy=%b x=%h, want res=000 busy=0 x=%h", res_valid_o, busy_o, x_o,
                  rot_x(16'h1000, 16'h0000, 16'h0861));
      end
   endtask

   task automatic test_done_hold();
      int n;
      eng_mode = ENG_HOLD;
      xs[1] = 16'h0700; ys[1] = 16'hFE00; as[1] = 16'h0400;
      load_ops();
      req_i = 3'b001;
      wait_ack(n);
      req_i = '0;
      wait_res(n);
      checks++;
      if (n != 13 || res_valid_o !== 3'b001) begin
         errors++;
         $display("FAIL hold_first: n=%0d res=%b, want n=13 res=001", n, res_valid_o);
      end
      repeat (3) @(negedge clk);
      req_i = 3'b010;
      wait_ack(n);
      checks++;
      if (n != 1 || ack_o !== 3'b010) begin
         errors++;
         $display("FAIL hold_ack: n=%0d ack=%b, want n=1 ack=010", n, ack_o);
      end
      req_i = '0;
      wait_res(n);
      checks++;
      if (n != 13 || res_valid_o !== 3'b010 || x_o !== rot_x(xs[1], ys[1], as[1]) || y_o !== rot_y(xs[1], ys[1], as[1])) begin
         errors++;
         $display("FAIL hold_second: n=%0d res=%b x=%h y=%h, want n=13 res=010 x=%h y=%h", n, res_valid_o, x_o, y_o,
                  rot_x(xs[1], ys[1], as[1]), rot_y(xs[1], ys[1], as[1]));
      end
      eng_mode = ENG_PULSE;
   endtask

   task automatic test_watchdog();
      int n;
      eng_mode = ENG_NEVER;
      req_i = 3'b100;
      wait_ack(n);
      checks++;
      if (n != 1 || ack_o !== 3'b100 || err_o !== 1'b0) begin
         errors++;
         $display("FAIL wd_ack: n=%0d ack=%b err=%b, want n=1 ack=100 err=0", n, ack_o, err_o);
      end
      req_i = '0;
      wait_res(n);
      checks++;
      if (n != TMO + 1 || res_valid_o !== 3'b100 || err_o !== 1'b1 || x_o !== '0 || y_o !== '0) begin
         errors++;
         $display("FAIL wd_abort: n=%0d res=%b err=%b x=%h y=%h, want n=%0d res=100 err=1 x=0 y=0", n, res_valid_o, err_o, x_o, y_o, TMO + 1);
      end
      eng_mode = ENG_PULSE;
      req_i = 3'b001;
      wait_ack(n);
      req_i = '0;
      checks++;
      if (n != 1 || ack_o !== 3'b001) begin
         errors++;
         $display("FAIL wd_next_ack: n=%0d ack=%b, want n=1 ack=001", n, ack_o);
      end
      wait_res(n);
      checks++;
      if (n != 13 || err_o !== 1'b1 || x_o !== rot_x(xs[0], ys[0], as[0])) begin
         errors++;
         $display("FAIL wd_next_res: n=%0d err=%b x=%h, want n=13 err=1 x=%h", n, err_o, x_o, rot_x(xs[0], ys[0], as[0]));
      end
   endtask

   task automatic test_reset_mid();
      int  n;
      logic seen;
      req_i = 3'b010;
      wait_ack(n);
      req_i = '0;
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (busy_o !== 1'b0 || err_o !== 1'b0 || eng_start_o !== 1'b0 || x_o !== '0 || y_o !== '0 ||
          eng_x_o !== '0 || ack_o !== '0 || res_valid_o !== '0) begin
         errors++;
         $display("FAIL async_reset: busy=%b err=%b start=%b x=%h y=%h ex=%h, want all 0", busy_o, err_o, eng_start_o, x_o, y_o, eng_x_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (res_valid_o !== '0 || busy_o !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL reset_drop: stale res_valid or busy after reset, want none");
      end
      req_i = 3'b110;
      wait_ack(n);
      req_i = '0;
      checks++;
      if (n != 1 || ack_o !== 3'b010) begin
         errors++;
         $display("FAIL reset_rr: n=%0d ack=%b, want n=1 ack=010", n, ack_o);
      end
      wait_res(n);
      checks++;
      if (n != 13 || res_valid_o !== 3'b010 || x_o !== rot_x(xs[1], ys[1], as[1])) begin
         errors++;
         $display("FAIL reset_res: n=%0d res=%b x=%h, want n=13 res=010 x=%h", n, res_valid_o, x_o, rot_x(xs[1], ys[1], as[1]));
      end
   endtask

   task automatic test_withdraw();
      int   n;
      logic seen;
      req_i = 3'b001;
      wait_ack(n);
      req_i = '0;
      repeat (3) @(negedge clk);
      req_i = 3'b100;
      @(negedge clk);
      req_i = '0;
      wait_res(n);
      checks++;
      if (n != 9 || res_valid_o !== 3'b001) begin
         errors++;
         $display("FAIL withdraw_res: n=%0d res=%b, want n=9 res=001", n, res_valid_o);
      end
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (ack_o !== '0 || busy_o !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL withdraw_idle: ack or busy seen after withdrawn request, want idle");
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_single();
      test_done_hold();
      test_watchdog();
      test_reset_mid();
      test_withdraw();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete, errors=%0d", errors);
      $fatal(1, "timeout");
   end

endmodule
